bist_ctrl: RTL and testbench

Built-in self-test sequencer for the 4-bit pattern-generator LFSR. On a start pulse it seeds the generator and lets it free-run for a fixed number of patterns. During the run it compacts the circuit-under-test (CUT) response into an internal MISR, then compares the final signature against a golden value and reports pass/fail. It sits between the test-access logic (start/seed/golden) and the LFSR + CUT pair.

---
 rtl/bist_ctrl.sv | 117 +++++++++++
 tb/tb_bist_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bist_ctrl: LFSR-driven BIST sequencer with MISR compaction and pass/fail  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bist_ctrl #(
  parameter int NBIT  = 4,
  parameter int NPAT  = 15,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [NBIT-1:0] seed_i,
  input  logic [NBIT-1:0] golden_i,
  input  logic [NBIT-1:0] cut_resp_i,
  output logic            lfsr_rst_o,
  output logic [NBIT-1:0] lfsr_seed_o,
  output logic            lfsr_scan_in_o,
  output logic            run_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [NBIT-1:0] signature_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_CHECK = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NPAT - 1);

  state_e          state_q, state_d;
  logic [NBIT-1:0] seed_q, seed_d;
  logic [NBIT-1:0] misr_q, misr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            pass_q, pass_d;
  logic            done_q, done_d;
  logic [NBIT-1:0] misr_shift;

  // Same feedback taps as the pattern generator.
  assign misr_shift = {misr_q[NBIT-2:0], misr_q[NBIT-1] ^ misr_q[NBIT-2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      seed_q  <= '0;
      misr_q  <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          seed_d  = seed_i;
          misr_d  = '0;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        misr_d = misr_shift ^ cut_resp_i;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        pass_d  = (misr_q == golden_i);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything; the partial signature stays visible.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      misr_d  = misr_q;
      cnt_d   = cnt_q;
      pass_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign lfsr_rst_o     = rst | (state_q == S_LOAD);
  assign lfsr_seed_o    = seed_q;
  assign lfsr_scan_in_o = 1'b0;
  assign run_o          = (state_q == S_RUN);
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign signature_o    = misr_q;

endmodule
`default_nettype wire

// File: tb/tb_bist_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bist_ctrl: timeline model of the BIST run checked against two DUTs     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_bist_ctrl;

  localparam int NP [2] = '{15, 4};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_s [2];
  logic       abort_s [2];
  logic [3:0] seed_s  [2];
  logic [3:0] golden_s[2];
  logic [3:0] resp_s  [2];
  logic       mode    [2];
  logic [3:0] rconst  [2];

  logic       lrst [2];
  logic [3:0] lseed[2];
  logic       lscan[2];
  logic       run  [2];
  logic       busy [2];
  logic       done [2];
  logic       pass [2];
  logic [3:0] sig  [2];

  bist_ctrl #(.NBIT(4), .NPAT(15), .CNT_W(8)) u_dut15 (
    .clk(clk), .rst(rst), .start_i(start_s[0]), .abort_i(abort_s[0]),
    .seed_i(seed_s[0]), .golden_i(golden_s[0]), .cut_resp_i(resp_s[0]),
    .lfsr_rst_o(lrst[0]), .lfsr_seed_o(lseed[0]), .lfsr_scan_in_o(lscan[0]),
    .run_o(run[0]), .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]),
    .signature_o(sig[0])
  );

  bist_ctrl #(.NBIT(4), .NPAT(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .start_i(start_s[1]), .abort_i(abort_s[1]),
    .seed_i(seed_s[1]), .golden_i(golden_s[1]), .cut_resp_i(resp_s[1]),
    .lfsr_rst_o(lrst[1]), .lfsr_seed_o(lseed[1]), .lfsr_scan_in_o(lscan[1]),
    .run_o(run[1]), .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]),
    .signature_o(sig[1])
  );

  // Pattern generators fed by the DUT, and a simple CUT (generator xor 1010).
  logic [3:0] gen[2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      gen[i] <= lrst[i] ? lseed[i] : {gen[i][2:0], gen[i][3] ^ gen[i][2] ^ lscan[i]};
    end
  end
  assign resp_s[0] = mode[0] ? (gen[0] ^ 4'b1010) : rconst[0];
  assign resp_s[1] = mode[1] ? (gen[1] ^ 4'b1010) : rconst[1];

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  logic en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] misr_step(input logic [3:0] m, input logic [3:0] r);
    return {m[2:0], m[3] ^ m[2]} ^ r;
  endfunction

  // Model: ph = cycles since start was accepted (-1 when idle).
  // ph 0 = load, 1..NP = patterns applied, NP+1 = compare.
  int         ph   [2] = '{-1, -1};
  logic [3:0] mseed[2];
  logic [3:0] mmisr[2];
  logic       mpass[2];
  logic       mdone[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ph[i] <= -1; mseed[i] <= 4'h0; mmisr[i] <= 4'h0; mpass[i] <= 1'b0; mdone[i] <= 1'b0;
      end else begin
        mdone[i] <= (ph[i] == NP[i] + 1) && !abort_s[i];
        if (ph[i] < 0) begin
          if (start_s[i]) begin
            ph[i] <= 0; mseed[i] <= seed_s[i]; mmisr[i] <= 4'h0;
          end
        end else if (abort_s[i]) begin
          ph[i] <= -1; mpass[i] <= 1'b0;
        end else if (ph[i] == NP[i] + 1) begin
          ph[i] <= -1; mpass[i] <= (mmisr[i] == golden_s[i]);
        end else begin
          if (ph[i] >= 1) mmisr[i] <= misr_step(mmisr[i], resp_s[i]);
          ph[i] <= ph[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy[%0d]", i),      busy[i],  ph[i] >= 0);
        chk($sformatf("run[%0d]", i),       run[i],   (ph[i] >= 1) && (ph[i] <= NP[i]));
        chk($sformatf("lfsr_rst[%0d]", i),  lrst[i],  rst || (ph[i] == 0));
        chk($sformatf("lfsr_seed[%0d]", i), lseed[i], mseed[i]);
        chk($sformatf("scan_in[%0d]", i),   lscan[i], 1'b0);
        chk($sformatf("done[%0d]", i),      done[i],  mdone[i]);
        chk($sformatf("pass[%0d]", i),      pass[i],  mpass[i]);
        chk($sformatf("signature[%0d]", i), sig[i],   mmisr[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] pats[16];
  int npats;
  int runs, rsts, c0;

  // Called in the load cycle; returns in the done cycle (or after a bound).
  task automatic run_until_done(input int i);
    int n;
    n = 0; runs = 0; rsts = 0; npats = 0;
    while (!done[i] && n < 60) begin
      if (run[i]) begin
        if (npats < 16) pats[npats] = gen[i];
        npats++;
        runs++;
      end
      if (lrst[i]) rsts++;
      tick();
      n++;
    end
    chk($sformatf("done_reached[%0d]", i), done[i], 1'b1);
  endtask

  task automatic pulse_start(input int i);
    start_s[i] = 1'b1;
    tick();
    start_s[i] = 1'b0;
    c0 = cyc;
  endtask

  task automatic no_done_for(input int i, input int n);
    int nd;
    nd = 0;
    for (int k = 0; k < n; k++) begin
      if (done[i]) nd++;
      tick();
    end
    chk($sformatf("no_done[%0d]", i), nd, 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; abort_s[i] = 1'b0; seed_s[i] = 4'h0;
      golden_s[i] = 4'h0; mode[i] = 1'b0; rconst[i] = 4'h0;
    end
    #2;
    chk("lfsr_rst_in_reset", lrst[0], 1'b1);
    tick();
    en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_done", done[0], 1'b0);
    chk("rst_pass", pass[0], 1'b0);
    chk("rst_sig", sig[0], 4'h0);
    chk("rst_lfsr_rst", lrst[0], 1'b0);
    chk("rst_scan", lscan[0], 1'b0);

    // Zero response, NPAT=15.
    seed_s[0] = 4'b1111; golden_s[0] = 4'b0000; rconst[0] = 4'b0000;
    pulse_start(0);
    chk("load_lfsr_rst", lrst[0], 1'b1);
    chk("load_seed", lseed[0], 4'b1111);
    run_until_done(0);
    chk("zero_latency", cyc - c0 + 1, 18);
    chk("zero_run_cycles", runs, 15);
    chk("zero_lrst_cycles", rsts, 1);
    chk("zero_pass", pass[0], 1'b1);
    chk("zero_sig", sig[0], 4'b0000);

    // Constant response 0001, NPAT=4.
    seed_s[1] = 4'b1111; rconst[1] = 4'b0001; golden_s[1] = 4'b1110;
    pulse_start(1);
    tick(); tick();
    chk("c4_sig1", sig[1], 4'b0001);
    tick();
    chk("c4_sig2", sig[1], 4'b0011);
    tick();
    chk("c4_sig3", sig[1], 4'b0111);
    tick();
    chk("c4_sig4", sig[1], 4'b1110);
    tick();
    chk("c4_done", done[1], 1'b1);
    chk("c4_pass", pass[1], 1'b1);
    golden_s[1] = 4'b1111;
    pulse_start(1);
    run_until_done(1);
    chk("c4_latency", cyc - c0 + 1, 7);
    chk("c4_fail_pass", pass[1], 1'b0);
    chk("c4_fail_sig", sig[1], 4'b1110);

    // Generator integration with a generator-driven CUT.
    mode[0] = 1'b1; seed_s[0] = 4'b1111; golden_s[0] = 4'b0000;
    pulse_start(0);
    run_until_done(0);
    chk("gen_npats", npats, 15);
    chk("gen_p0", pats[0], 4'b1111);
    chk("gen_p1", pats[1], 4'b1110);
    chk("gen_p2", pats[2], 4'b1100);
    chk("gen_p3", pats[3], 4'b1000);
    chk("gen_p4", pats[4], 4'b0001);
    chk("gen_p14", pats[14], 4'b0111);
    golden_s[0] = mmisr[0];
    pulse_start(0);
    run_until_done(0);
    chk("gen_pass", pass[0], 1'b1);

    // Abort in the third RUN cycle.
    mode[0] = 1'b0; rconst[0] = 4'b0011; golden_s[0] = 4'b0000;
    pulse_start(0);
    tick(); tick(); tick();
    abort_s[0] = 1'b1;
    tick();
    abort_s[0] = 1'b0;
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_done", done[0], 1'b0);
    chk("abort_pass", pass[0], 1'b0);
    no_done_for(0, 25);
    rconst[0] = 4'b0000;
    pulse_start(0);
    run_until_done(0);
    chk("post_abort_latency", cyc - c0 + 1, 18);
    chk("post_abort_pass", pass[0], 1'b1);

    // Start during RUN is ignored.
    pulse_start(0);
    tick(); tick(); tick();
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    run_until_done(0);
    chk("ign_start_latency", cyc - c0 + 1, 18);

    // Start in the done cycle.
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    c0 = cyc;
    chk("restart_busy", busy[0], 1'b1);
    chk("restart_lrst", lrst[0], 1'b1);
    run_until_done(0);
    chk("restart_latency", cyc - c0 + 1, 18);

    // Reset mid-RUN.
    rconst[0] = 4'b0101;
    pulse_start(0);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", busy[0], 1'b0);
    chk("midrst_sig", sig[0], 4'b0000);
    chk("midrst_done", done[0], 1'b0);
    chk("midrst_seed", lseed[0], 4'b0000);
    no_done_for(0, 25);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
`default_nettype wire
